// File: rtl/param_register_file.sv
// rtl/param_register_file.sv - parametrised 2R/1W register file with bypass, valid flags and sequential clear
//
// Purpose:
//   Register file between decode (read addresses) and writeback (write port).
//   Two asynchronous read ports and one synchronous write port. Optional
//   hard-wired zero register, optional write-to-read bypass, one valid flag
//   per entry, and a clear engine that zeroes one entry per cycle.
//
// Ports:
//   clock           rising-edge clock
//   reset           synchronous, active-low reset
//   read_register1  read port 1 address
//   read_register2  read port 2 address
//   write_enable    active-low write strobe
//   write_register  write address
//   write_data      write data
//   clear_req       one-cycle pulse that starts a sequential clear
//   read_data1      read port 1 data (combinational)
//   read_data2      read port 2 data (combinational)
//   read_valid1     entry at read_register1 written since last reset/clear
//   read_valid2     entry at read_register2 written since last reset/clear
//   busy            clear engine active; write port blocked
//   clear_done      one-cycle pulse after the last entry has been cleared

module param_register_file #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 2,
   parameter int ZERO_REG   = 0,
   parameter int BYPASS     = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] read_register1,
   input  logic [ADDR_WIDTH-1:0] read_register2,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] write_register,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  clear_req,
   output logic [DATA_WIDTH-1:0] read_data1,
   output logic [DATA_WIDTH-1:0] read_data2,
   output logic                  read_valid1,
   output logic                  read_valid2,
   output logic                  busy,
   output logic                  clear_done
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [ADDR_WIDTH-1:0] r_clr_addr;
   logic [ADDR_WIDTH-1:0] w_clr_addr_next;
   logic                  r_clear_done;
   logic                  w_clear_done_next;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]      r_valid;

   logic                  w_busy;
   logic                  w_wr_drop_zero;
   logic                  w_wr_accept;

   assign w_busy = (r_state == S_CLEAR);

   // Writes to entry 0 vanish when it is the hard-wired zero register.
   assign w_wr_drop_zero = (ZERO_REG != 0) && (write_register == '0);

   // A write lands only when the strobe is low and the clear engine is idle;
   // the same qualifier gates bypass so forwarding never shows dropped data.
   assign w_wr_accept = !write_enable && !w_busy && !w_wr_drop_zero;

   // Clear FSM: state register.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_clr_addr   <= '0;
         r_clear_done <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_clr_addr   <= w_clr_addr_next;
         r_clear_done <= w_clear_done_next;
      end
   end

   // Clear FSM: next state. clear_req is only looked at in IDLE, so a
   // request arriving mid-clear does not restart the sweep.
   always_comb begin
      w_state_next      = r_state;
      w_clr_addr_next   = r_clr_addr;
      w_clear_done_next = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (clear_req) begin
               w_state_next    = S_CLEAR;
               w_clr_addr_next = '0;
            end
         end
         S_CLEAR: begin
            if (r_clr_addr == LAST_ADDR) begin
               w_state_next      = S_IDLE;
               w_clr_addr_next   = '0;
               w_clear_done_next = 1'b1;
            end else begin
               w_clr_addr_next = r_clr_addr + 1'b1;
            end
         end
         default: begin
            w_state_next    = S_IDLE;
            w_clr_addr_next = '0;
         end
      endcase
   end

   // Storage array and valid flags. While clearing, the engine owns the
   // array; a write in the cycle clear_req is taken still lands because
   // the FSM is still IDLE at that edge.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_valid <= '0;
      end else if (w_busy) begin
         r_mem[r_clr_addr]   <= '0;
         r_valid[r_clr_addr] <= 1'b0;
      end else if (w_wr_accept) begin
         r_mem[write_register]   <= write_data;
         r_valid[write_register] <= 1'b1;
      end
   end

   // Read port 1. The zero register takes priority over bypass, although
   // the two never collide because a write to entry 0 is not accepted then.
   always_comb begin
      read_data1  = r_mem[read_register1];
      read_valid1 = r_valid[read_register1];
      if ((BYPASS != 0) && w_wr_accept && (write_register == read_register1)) begin
         read_data1  = write_data;
         read_valid1 = 1'b1;
      end
      if ((ZERO_REG != 0) && (read_register1 == '0)) begin
         read_data1  = '0;
         read_valid1 = 1'b1;
      end
   end

   // Read port 2, identical to port 1.
   always_comb begin
      read_data2  = r_mem[read_register2];
      read_valid2 = r_valid[read_register2];
      if ((BYPASS != 0) && w_wr_accept && (write_register == read_register2)) begin
         read_data2  = write_data;
         read_valid2 = 1'b1;
      end
      if ((ZERO_REG != 0) && (read_register2 == '0)) begin
         read_data2  = '0;
         read_valid2 = 1'b1;
      end
   end

   assign busy       = w_busy;
   assign clear_done = r_clear_done;

endmodule
